// File: rtl/mx_dot_acc.sv
// Exact block accumulator: sums blk_size signed products into one dot-product result per MX block.
// Optional MX_DOT_ACC_LAST_EN adds i_prd_last so a product can close a short block early.
module mx_dot_acc #(
    parameter int exp_width = 5,
    parameter int man_width = 2,
    parameter int blk_size  = 32,
    parameter int prd_width = 2*((1<<exp_width)+man_width),
    parameter int acc_width = prd_width + $clog2(blk_size)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_prd_valid,
    output logic                 o_prd_ready,
    input  logic [prd_width-1:0] i_prd,
`ifdef MX_DOT_ACC_LAST_EN
    input  logic                 i_prd_last,
`endif
    output logic                 o_acc_valid,
    input  logic                 i_acc_ready,
    output logic [acc_width-1:0] o_acc
);
    localparam int cnt_width = $clog2(blk_size);
    localparam logic [cnt_width-1:0] cnt_last = cnt_width'(blk_size-1);

    logic [acc_width-1:0] acc;
    logic [cnt_width-1:0] cnt;
    logic [acc_width-1:0] prd_ext;
    logic [acc_width-1:0] sum;
    logic                 is_final;
    logic                 accept;
    logic                 out_take;

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // valid never waits for ready, ready never looks at valid, data is held while valid & !ready.
`ifdef MX_DOT_ACC_LAST_EN
    assign is_final = (cnt == cnt_last) | i_prd_last;
`else
    assign is_final = (cnt == cnt_last);
`endif

    // Only a block-closing product needs the output register, so only it stalls.
    assign o_prd_ready = !(is_final & o_acc_valid & !i_acc_ready);
    assign accept      = i_prd_valid & o_prd_ready;
    assign out_take    = o_acc_valid & i_acc_ready;

    assign prd_ext = {{(acc_width-prd_width){i_prd[prd_width-1]}}, i_prd};
    assign sum     = acc + prd_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            if (is_final) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + cnt_width'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_acc       <= '0;
            o_acc_valid <= 1'b0;
        end else if (accept & is_final) begin
            o_acc       <= sum;
            o_acc_valid <= 1'b1;
        end else if (out_take) begin
            o_acc_valid <= 1'b0;
        end
    end
endmodule
